// File: rtl/memory_dp_hs.sv
// memory_dp_hs: dual-port synchronous memory with valid/ready requests.
// Port A is read-only (instruction fetch). Port B reads and writes with
// per-byte strobes (data stage). Each accepted request gets a registered
// response one cycle later. Misaligned or out-of-range accesses return an
// error. A post-reset sequencer can zero the whole array before the ports open.
module memory_dp_hs #(
  parameter int    DATA_WIDTH          = 32,
  parameter int    NUM_BYTES           = 64,
  parameter string INITIAL_MEMORY_FILE = "",
  parameter bit    CLEAR_ON_RESET      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_done,
  input  logic                    a_req_valid,
  output logic                    a_req_ready,
  input  logic [31:0]             a_addr,
  output logic                    a_rsp_valid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_err,
  input  logic                    b_req_valid,
  output logic                    b_req_ready,
  input  logic                    b_we,
  input  logic [31:0]             b_addr,
  input  logic [DATA_WIDTH/8-1:0] b_wstrb,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_rsp_valid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_err,
  output logic [7:0]              err_count
);

  localparam int BPW      = DATA_WIDTH / 8;
  localparam int DEPTH    = NUM_BYTES / BPW;
  localparam int LB       = $clog2(BPW);
  localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit HAS_FILE = (INITIAL_MEMORY_FILE != "");
  localparam bit DO_CLEAR = CLEAR_ON_RESET && !HAS_FILE;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state;
  logic [IW-1:0]         clr_idx;
  logic                  run;
  logic                  a_acc, b_acc;
  logic                  a_bad, b_bad;
  logic [IW-1:0]         a_idx, b_idx;
  logic                  b_wr;
  logic [DATA_WIDTH-1:0] b_merged;
  logic [DATA_WIDTH-1:0] a_word;
  logic [1:0]            err_inc;
  logic [8:0]            err_sum;

  // An access is bad if it is not word aligned or falls past the last byte.
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[LB-1:0] != '0) || (addr >= 32'(NUM_BYTES));
  endfunction

  assign run         = (state == ST_RUN);
  assign init_done   = run;
  assign a_req_ready = run;
  assign b_req_ready = run;

  assign a_acc = a_req_valid && run;
  assign b_acc = b_req_valid && run;
  assign a_bad = addr_bad(a_addr);
  assign b_bad = addr_bad(b_addr);
  assign a_idx = IW'(a_addr >> LB);
  assign b_idx = IW'(b_addr >> LB);
  assign b_wr  = b_acc && b_we && !b_bad;

  // Merge enabled write bytes into the current word; a read sees the stored word.
  always_comb begin
    // NOTE: assign a default before the conditional updates so no latch is inferred.
    b_merged = mem[b_idx];
    if (b_we) begin
      for (int i = 0; i < BPW; i++) begin
        if (b_wstrb[i]) b_merged[8*i +: 8] = b_wdata[8*i +: 8];
      end
    end
  end

  // Port A sees a same-cycle port B write to its word (write-first across ports).
  always_comb begin
    a_word = mem[a_idx];
    if (b_wr && (b_idx == a_idx)) a_word = b_merged;
  end

  assign err_inc = {1'b0, a_acc && a_bad} + {1'b0, b_acc && b_bad};
  assign err_sum = {1'b0, err_count} + {7'b0, err_inc};

  // Array write port: clearing sequencer or port B. These never overlap,
  // because port B is only accepted in RUN.
  // NOTE: the array deliberately has no reset, so it maps onto block RAM and
  // keeps its contents across rst_n.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[clr_idx] <= '0;
    else if (b_wr)         mem[b_idx]   <= b_merged;
  end

  // Init sequencer: RESET -> optional CLEAR sweep -> RUN until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values.
    if (!rst_n) begin
      state   <= ST_RESET;
      clr_idx <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          clr_idx <= '0;
          state   <= DO_CLEAR ? ST_CLEAR : ST_RUN;
        end
        ST_CLEAR: begin
          if (clr_idx == IW'(DEPTH - 1)) state   <= ST_RUN;
          else                           clr_idx <= clr_idx + 1'b1;
        end
        ST_RUN:   state <= ST_RUN;
        default:  state <= ST_RESET;
      endcase
    end
  end

  // Registered responses: one-cycle valid pulse. Data and error hold in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_valid <= 1'b0;
      a_rdata     <= '0;
      a_err       <= 1'b0;
      b_rsp_valid <= 1'b0;
      b_rdata     <= '0;
      b_err       <= 1'b0;
    end else begin
      a_rsp_valid <= a_acc;
      b_rsp_valid <= b_acc;
      if (a_acc) begin
        a_err   <= a_bad;
        a_rdata <= a_bad ? '0 : a_word;
      end
      if (b_acc) begin
        b_err   <= b_bad;
        b_rdata <= b_bad ? '0 : b_merged;
      end
    end
  end

  // Saturating error counter covering both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count <= 8'd0;
    else        err_count <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

endmodule

// File: tb/tb_memory_dp_hs.sv
// Testbench for memory_dp_hs: directed vectors, a behavioural model compared
// on every cycle, and hand-computed literal expectations.
module tb_memory_dp_hs;

  localparam int DW     = 32;
  localparam int NB     = 64;
  localparam int BPW    = DW / 8;
  localparam int DEPTH  = NB / BPW;
  localparam int RUN_AT = DEPTH + 1;  // one RESET edge plus DEPTH clearing edges

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic          a_req_valid, a_req_ready, a_rsp_valid, a_err;
  logic [31:0]   a_addr;
  logic [DW-1:0] a_rdata;
  logic          b_req_valid, b_req_ready, b_we, b_rsp_valid, b_err;
  logic [31:0]   b_addr;
  logic [BPW-1:0] b_wstrb;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  memory_dp_hs #(
    .DATA_WIDTH(DW), .NUM_BYTES(NB), .INITIAL_MEMORY_FILE(""), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr),
    .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_we(b_we),
    .b_addr(b_addr), .b_wstrb(b_wstrb), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata), .b_err(b_err),
    .err_count(err_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            e = 0;  // rising edges seen with rst_n high since the last reset
  logic [DW-1:0] m_mem [DEPTH];
  logic          x_a_valid, x_b_valid, x_a_err, x_b_err;
  logic [DW-1:0] x_a_rdata, x_b_rdata;
  int            x_cnt;

  function automatic bit bad_addr(input logic [31:0] addr);
    return ((addr % BPW) != 0) || (addr >= NB);
  endfunction

  always begin : model
    logic          rdy, a_acc, b_acc;
    logic [DW-1:0] w;
    logic [3:0]    wi;
    int            errs;
    @(posedge clk);
    if (!rst_n) begin
      e = 0;
      x_a_valid = 1'b0; x_b_valid = 1'b0; x_a_err = 1'b0; x_b_err = 1'b0;
      x_a_rdata = '0;   x_b_rdata = '0;   x_cnt = 0;
    end else begin
      rdy   = (e >= RUN_AT);
      a_acc = rdy && a_req_valid;
      b_acc = rdy && b_req_valid;
      errs  = 0;
      x_a_valid = a_acc;
      x_b_valid = b_acc;
      // Port B first so that port A observes the new word.
      if (b_acc) begin
        if (bad_addr(b_addr)) begin
          x_b_err = 1'b1; x_b_rdata = '0; errs++;
        end else begin
          wi = 4'(b_addr / BPW);
          w  = m_mem[wi];
          if (b_we)
            for (int i = 0; i < BPW; i++)
              if (b_wstrb[i]) w[8*i +: 8] = b_wdata[8*i +: 8];
          m_mem[wi] = w;
          x_b_err = 1'b0; x_b_rdata = w;
        end
      end
      if (a_acc) begin
        if (bad_addr(a_addr)) begin
          x_a_err = 1'b1; x_a_rdata = '0; errs++;
        end else begin
          x_a_err = 1'b0; x_a_rdata = m_mem[4'(a_addr / BPW)];
        end
      end
      x_cnt = (x_cnt + errs > 255) ? 255 : x_cnt + errs;
      if (e < RUN_AT) begin
        e++;
        if (e == RUN_AT) for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
      end
    end
    #1;
    check("m_init_done",   32'(init_done),   32'(e >= RUN_AT));
    check("m_a_req_ready", 32'(a_req_ready), 32'(e >= RUN_AT));
    check("m_b_req_ready", 32'(b_req_ready), 32'(e >= RUN_AT));
    check("m_a_rsp_valid", 32'(a_rsp_valid), 32'(x_a_valid));
    check("m_b_rsp_valid", 32'(b_rsp_valid), 32'(x_b_valid));
    check("m_a_rdata",     a_rdata,          x_a_rdata);
    check("m_b_rdata",     b_rdata,          x_b_rdata);
    check("m_a_err",       32'(a_err),       32'(x_a_err));
    check("m_b_err",       32'(b_err),       32'(x_b_err));
    check("m_err_count",   32'(err_count),   32'(x_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    a_req_valid = 1'b0; a_addr = '0;
    b_req_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wstrb = '0; b_wdata = '0;
  endtask

  task automatic a_set(input logic [31:0] addr);
    a_req_valid = 1'b1; a_addr = addr;
  endtask

  task automatic b_set(input logic we, input logic [31:0] addr,
                       input logic [BPW-1:0] strb, input logic [DW-1:0] data);
    b_req_valid = 1'b1; b_we = we; b_addr = addr; b_wstrb = strb; b_wdata = data;
  endtask

  // Count rising edges after release at which init_done is still low.
  task automatic wait_init(input string name);
    int lows = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (init_done === 1'b1) break;
      lows++;
    end
    check(name, lows, DEPTH);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick(); tick();
    check("rst_init_done", 32'(init_done),   0);
    check("rst_a_ready",   32'(a_req_ready), 0);
    check("rst_b_ready",   32'(b_req_ready), 0);
    check("rst_rsp_valid", 32'({a_rsp_valid, b_rsp_valid}), 0);
    check("rst_a_rdata",   a_rdata, 0);
    check("rst_err_count", 32'(err_count), 0);
    rst_n = 1'b1;
    wait_init("init_latency_first");

    // Preload word i = {i[15:0], i[15:0]} through port B.
    for (int i = 0; i < DEPTH; i++) begin
      b_set(1'b1, 32'(4 * i), 4'hF, {16'(i), 16'(i)});
      tick();
    end
    idle();
    tick();

    // 1: back-to-back reads give back-to-back responses.
    b_set(1'b0, 32'h0, 4'h0, '0); tick();
    check("t1_valid0", 32'(b_rsp_valid), 1);
    check("t1_rdata0", b_rdata, 32'h0000_0000);
    b_set(1'b0, 32'h4, 4'hF, 32'hFFFF_FFFF); tick();  // strobes ignored on a read
    check("t1_valid1", 32'(b_rsp_valid), 1);
    check("t1_rdata1", b_rdata, 32'h0001_0001);
    b_set(1'b0, 32'h8, 4'h0, '0); tick();
    check("t1_valid2", 32'(b_rsp_valid), 1);
    check("t1_rdata2", b_rdata, 32'h0002_0002);
    check("t1_err",    32'(b_err), 0);
    idle(); tick();
    check("t1_pulse_end", 32'(b_rsp_valid), 0);
    check("t1_hold",      b_rdata, 32'h0002_0002);

    // 2: full write, partial strobe merge, no-op write, cross-port read.
    b_set(1'b1, 32'h4, 4'hF, 32'h0123_4567); tick();
    check("t2_full", b_rdata, 32'h0123_4567);
    b_set(1'b1, 32'h4, 4'b0101, 32'hAABB_CCDD); tick();
    check("t2_merge", b_rdata, 32'h01BB_45DD);
    b_set(1'b1, 32'h4, 4'h0, 32'h1111_1111); tick();
    check("t2_noop", b_rdata, 32'h01BB_45DD);
    idle(); a_set(32'h4); tick();
    check("t2_a_read", a_rdata, 32'h01BB_45DD);

    // 3: same-cycle collision, write-first across ports.
    a_set(32'h8); b_set(1'b1, 32'h8, 4'hF, 32'hDEAD_BEEF); tick();
    check("t3_a_rdata", a_rdata, 32'hDEAD_BEEF);
    check("t3_b_rdata", b_rdata, 32'hDEAD_BEEF);
    idle(); tick();

    // 4: errors, no array write, saturating count.
    b_set(1'b0, 32'h2, 4'h0, '0); a_set(32'h40); tick();
    check("t4_a_err",   32'(a_err), 1);
    check("t4_b_err",   32'(b_err), 1);
    check("t4_a_rdata", a_rdata, 0);
    check("t4_b_rdata", b_rdata, 0);
    check("t4_count2",  32'(err_count), 2);
    idle(); b_set(1'b1, 32'h6, 4'hF, 32'h5555_5555); tick();  // misaligned write
    check("t4_count3",  32'(err_count), 3);
    idle(); a_set(32'h4); b_set(1'b0, 32'h0, 4'h0, '0); tick();
    check("t4_unchanged_a", a_rdata, 32'h01BB_45DD);
    check("t4_unchanged_b", b_rdata, 32'h0000_0000);
    for (int i = 0; i < 150; i++) begin
      a_set(32'h41); b_set(1'b1, 32'h7C + 32'(4 * i), 4'hF, 32'hFFFF_FFFF);
      tick();
      if (i == 99) check("t4_count203", 32'(err_count), 203);
    end
    check("t4_count_sat", 32'(err_count), 255);
    idle(); tick();
    check("t4_count_hold", 32'(err_count), 255);

    // 5: reset pulse triggers a full clear.
    pulse_reset();
    check("t5_count_rst", 32'(err_count), 0);
    wait_init("init_latency_clear");
    for (int j = 0; j < DEPTH / 2; j++) begin
      a_set(32'(8 * j)); b_set(1'b0, 32'(8 * j + 4), 4'h0, '0); tick();
      check("t5_a_zero", a_rdata, 0);
      check("t5_b_zero", b_rdata, 0);
    end
    idle(); tick();

    // 6: reset mid-clear restarts the sweep; pending responses are dropped.
    b_set(1'b1, 32'hC, 4'hF, 32'h1234_5678); tick();
    check("t6_written", b_rdata, 32'h1234_5678);
    idle();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();  // clearing word 7 now
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    wait_init("init_latency_abort");
    a_set(32'hC); tick();
    check("t6_cleared", a_rdata, 0);
    a_set(32'h0); b_set(1'b1, 32'h0, 4'hF, 32'h0000_0099); tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("t6_drop_a", 32'(a_rsp_valid), 0);
    check("t6_drop_b", 32'(b_rsp_valid), 0);
    tick();
    check("t6_still_low", 32'({a_rsp_valid, b_rsp_valid}), 0);
    rst_n = 1'b1;
    wait_init("init_latency_last");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
